// File: rtl/f1_game_pkg.sv
// Shared types and constants for the F1 reaction-time game controller.
package f1_game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SEQ,
        FULL,
        TIMING,
        DONE,
        JUMP,
        TOUT
    } state_t;

    localparam logic [7:0] LIGHTS_ALL_ON   = 8'hFF;
    localparam int         CLKS_PER_MS_DEF = 50000;
    localparam int         TIMEOUT_MS_DEF  = 2000;
    localparam int         TIME_WIDTH_DEF  = 16;

endpackage

// File: rtl/f1_reaction_ctrl_if.sv
// Signal bundle between the game controller and its surroundings (buttons, lights, display).
interface f1_reaction_ctrl_if #(
    parameter int LIGHTS_WIDTH = 8,
    parameter int TIME_WIDTH   = 16
);
    logic                    start_btn;
    logic                    react_btn;
    logic [LIGHTS_WIDTH-1:0] lights;
    logic                    trigger;
    logic                    busy;
    logic [TIME_WIDTH-1:0]   react_time;
    logic                    result_valid;
    logic                    jump_start;
    logic                    timeout;
    logic [TIME_WIDTH-1:0]   best_time;

    modport master (
        output start_btn, react_btn, lights,
        input  trigger, busy, react_time, result_valid, jump_start, timeout, best_time
    );

    modport slave (
        input  start_btn, react_btn, lights,
        output trigger, busy, react_time, result_valid, jump_start, timeout, best_time
    );
endinterface

// File: rtl/f1_reaction_ctrl_ms_timer.sv
// Millisecond timebase: prescaler plus a saturating ms counter with a timeout compare.
module ms_timer #(
    parameter int CLKS_PER_MS = 50000,
    parameter int TIME_WIDTH  = 16,
    parameter int TIMEOUT_MS  = 2000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  enable,
    output logic [TIME_WIDTH-1:0] ms_count,
    output logic                  limit_hit
);
    localparam int                    PW         = $clog2(CLKS_PER_MS);
    localparam logic [PW-1:0]         PRESC_LAST = PW'(CLKS_PER_MS - 1);
    localparam logic [TIME_WIDTH-1:0] MS_LIMIT   = TIME_WIDTH'(TIMEOUT_MS);

    logic [PW-1:0]         presc_q, presc_d;
    logic [TIME_WIDTH-1:0] ms_q, ms_d;

    always_comb begin
        presc_d = presc_q;
        ms_d    = ms_q;
        if (clear) begin
            presc_d = '0;
            ms_d    = '0;
        end else if (enable) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                // Hold at all-ones rather than wrapping back to a small time.
                if (ms_q != '1) begin
                    ms_d = ms_q + TIME_WIDTH'(1);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q <= '0;
            ms_q    <= '0;
        end else begin
            presc_q <= presc_d;
            ms_q    <= ms_d;
        end
    end

    assign ms_count  = ms_q;
    assign limit_hit = (ms_q >= MS_LIMIT);
endmodule

// File: rtl/f1_reaction_ctrl.sv
// F1 lights-out game controller: triggers the lights, times the driver reaction, flags fouls.
module f1_reaction_ctrl
    import f1_game_pkg::*;
#(
    parameter int LIGHTS_WIDTH = $bits(LIGHTS_ALL_ON),
    parameter int CLKS_PER_MS  = CLKS_PER_MS_DEF,
    parameter int TIME_WIDTH   = TIME_WIDTH_DEF,
    parameter int TIMEOUT_MS   = TIMEOUT_MS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    f1_reaction_ctrl_if.slave bus
);
    state_t                state_q, state_d;
    logic                  start_prev_q, react_prev_q;
    logic                  result_valid_q, result_valid_d;
    logic                  jump_start_q, jump_start_d;
    logic                  timeout_q, timeout_d;
    logic [TIME_WIDTH-1:0] react_time_q, react_time_d;
    logic [TIME_WIDTH-1:0] best_time_q, best_time_d;

    logic                  start_rise, react_rise, lights_full, lights_out;
    logic [TIME_WIDTH-1:0] ms_count;
    logic                  limit_hit;

    assign start_rise  = bus.start_btn & ~start_prev_q;
    assign react_rise  = bus.react_btn & ~react_prev_q;
    assign lights_full = &bus.lights;
    assign lights_out  = (bus.lights == '0);

    // The timer sits cleared outside TIMING, so it starts from zero on lights-out.
    ms_timer #(
        .CLKS_PER_MS(CLKS_PER_MS),
        .TIME_WIDTH (TIME_WIDTH),
        .TIMEOUT_MS (TIMEOUT_MS)
    ) u_ms_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q != TIMING),
        .enable   (state_q == TIMING),
        .ms_count (ms_count),
        .limit_hit(limit_hit)
    );

    always_comb begin
        state_d        = state_q;
        result_valid_d = 1'b0;
        jump_start_d   = jump_start_q;
        timeout_d      = timeout_q;
        react_time_d   = react_time_q;
        best_time_d    = best_time_q;
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d      = ARM;
                    jump_start_d = 1'b0;
                    timeout_d    = 1'b0;
                end
            end
            ARM:  state_d = SEQ;
            SEQ: begin
                if (react_rise) begin
                    state_d      = JUMP;
                    jump_start_d = 1'b1;
                end else if (lights_full) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                // A press coinciding with lights-out is still a jump start.
                if (react_rise) begin
                    state_d      = JUMP;
                    jump_start_d = 1'b1;
                end else if (lights_out) begin
                    state_d = TIMING;
                end
            end
            TIMING: begin
                if (react_rise) begin
                    state_d        = DONE;
                    react_time_d   = ms_count;
                    result_valid_d = 1'b1;
                    if (ms_count < best_time_q) begin
                        best_time_d = ms_count;
                    end
                end else if (limit_hit) begin
                    state_d   = TOUT;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        start_prev_q <= bus.start_btn;
        react_prev_q <= bus.react_btn;
        if (!rst) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
            jump_start_q   <= 1'b0;
            timeout_q      <= 1'b0;
            react_time_q   <= '0;
            best_time_q    <= '1;
        end else begin
            state_q        <= state_d;
            result_valid_q <= result_valid_d;
            jump_start_q   <= jump_start_d;
            timeout_q      <= timeout_d;
            react_time_q   <= react_time_d;
            best_time_q    <= best_time_d;
        end
    end

    assign bus.trigger      = (state_q == ARM);
    assign bus.busy         = (state_q == ARM) || (state_q == SEQ) ||
                              (state_q == FULL) || (state_q == TIMING);
    assign bus.react_time   = react_time_q;
    assign bus.result_valid = result_valid_q;
    assign bus.jump_start   = jump_start_q;
    assign bus.timeout      = timeout_q;
    assign bus.best_time    = best_time_q;
endmodule

// File: tb/tb_f1_reaction_ctrl.sv
// Scoreboard bench for f1_reaction_ctrl: results, jump starts and timeouts checked as events.
module tb_f1_reaction_ctrl;
    import f1_game_pkg::*;

    localparam int CPM = 4;
    localparam int TMO = 20;
    localparam int LW  = 8;
    localparam int TW  = 16;

    localparam int EV_RESULT = 0;
    localparam int EV_JUMP   = 1;
    localparam int EV_TOUT   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    f1_reaction_ctrl_if #(.LIGHTS_WIDTH(LW), .TIME_WIDTH(TW)) bus ();

    f1_reaction_ctrl #(
        .LIGHTS_WIDTH(LW),
        .CLKS_PER_MS (CPM),
        .TIME_WIDTH  (TW),
        .TIMEOUT_MS  (TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int          kind;
        logic [TW-1:0] rt;
        logic [TW-1:0] best;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fails  = 0;
    logic [TW-1:0] m_rt     = '0;
    logic [TW-1:0] m_best   = '1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Event monitor: one scoreboard pop per result pulse or sticky-flag rising edge.
    initial begin
        logic js_prev;
        logic to_prev;
        int   kind;
        exp_t e;
        js_prev = 1'b0;
        to_prev = 1'b0;
        forever begin
            @(negedge clk);
            kind = -1;
            if (rst === 1'b1) begin
                if (bus.result_valid)                kind = EV_RESULT;
                else if (bus.jump_start && !js_prev) kind = EV_JUMP;
                else if (bus.timeout && !to_prev)    kind = EV_TOUT;
            end
            if (kind >= 0) begin
                $display("txn kind=%0d react_time=%0d best_time=%0h", kind, bus.react_time, bus.best_time);
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("event_kind", 32'(kind), 32'(e.kind));
                    check("react_time", 32'(bus.react_time), 32'(e.rt));
                    check("best_time", 32'(bus.best_time), 32'(e.best));
                end
            end
            js_prev = bus.jump_start;
            to_prev = bus.timeout;
        end
    end

    task automatic do_start();
        bus.start_btn = 1'b1;
        tick();
        check("trigger_pulse", 32'(bus.trigger), 32'd1);
        check("busy_arm", 32'(bus.busy), 32'd1);
        check("flags_cleared", 32'({bus.jump_start, bus.timeout}), 32'd0);
        tick();
        check("trigger_once", 32'(bus.trigger), 32'd0);
        bus.start_btn = 1'b0;
    endtask

    task automatic build(input int n);
        logic [LW-1:0] v;
        for (int i = 1; i <= n; i++) begin
            v = LW'((1 << i) - 1);
            bus.lights = v;
            tick();
        end
    endtask

    task automatic run_normal(input int ms);
        do_start();
        build(8);
        tick();
        tick();
        bus.lights = '0;
        m_rt = TW'(ms);
        if (m_rt < m_best) m_best = m_rt;
        sb.push_back('{EV_RESULT, m_rt, m_best});
        repeat (CPM * ms + 1) tick();
        bus.react_btn = 1'b1;
        tick();
        tick();
        check("busy_after_result", 32'(bus.busy), 32'd0);
        check("no_jump_after_result", 32'(bus.jump_start), 32'd0);
        bus.react_btn = 1'b0;
    endtask

    task automatic expect_jump();
        bus.react_btn = 1'b1;
        sb.push_back('{EV_JUMP, m_rt, m_best});
        tick();
        check("jump_flag", 32'(bus.jump_start), 32'd1);
        tick();
        check("busy_after_jump", 32'(bus.busy), 32'd0);
        bus.react_btn = 1'b0;
        bus.lights = '0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        bus.start_btn = 1'b0;
        bus.react_btn = 1'b0;
        bus.lights    = '0;
        repeat (2) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_trigger", 32'(bus.trigger), 32'd0);
        check("rst_react_time", 32'(bus.react_time), 32'd0);
        check("rst_best_time", 32'(bus.best_time), 32'hFFFF);
        check("rst_flags", 32'({bus.result_valid, bus.jump_start, bus.timeout}), 32'd0);
        rst = 1'b1;
        tick();

        run_normal(7);
        run_normal(3);
        run_normal(9);

        // Jump start while lights are still building (0F).
        do_start();
        build(4);
        expect_jump();

        // Jump start during the full-on hold.
        do_start();
        build(8);
        tick();
        expect_jump();

        // React edge in the same cycle the lights go out.
        do_start();
        build(8);
        tick();
        bus.lights = '0;
        expect_jump();

        // Timeout: no react after lights-out.
        do_start();
        build(8);
        tick();
        bus.lights = '0;
        sb.push_back('{EV_TOUT, m_rt, m_best});
        repeat (79) tick();
        check("timeout_early", 32'(bus.timeout), 32'd0);
        check("busy_timing", 32'(bus.busy), 32'd1);
        repeat (6) tick();
        check("timeout_set", 32'(bus.timeout), 32'd1);
        check("busy_after_tout", 32'(bus.busy), 32'd0);
        bus.react_btn = 1'b1;
        tick();
        tick();
        check("late_react_rt", 32'(bus.react_time), 32'(m_rt));
        check("late_react_busy", 32'(bus.busy), 32'd0);
        bus.react_btn = 1'b0;
        tick();

        // New start clears timeout; then reset in the middle of TIMING.
        do_start();
        check("timeout_cleared", 32'(bus.timeout), 32'd0);
        build(8);
        tick();
        bus.lights = '0;
        repeat (10) tick();
        check("busy_pre_reset", 32'(bus.busy), 32'd1);
        bus.start_btn = 1'b1;
        rst = 1'b0;
        tick();
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_best", 32'(bus.best_time), 32'hFFFF);
        check("mid_rst_react_time", 32'(bus.react_time), 32'd0);
        check("mid_rst_flags", 32'({bus.result_valid, bus.jump_start, bus.timeout}), 32'd0);
        rst = 1'b1;
        m_rt   = '0;
        m_best = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_start_no_trigger", 32'({bus.trigger, bus.busy}), 32'd0);
        end
        bus.start_btn = 1'b0;
        tick();

        // Reaction inside the first millisecond.
        run_normal(0);

        repeat (3) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/f1_reaction_ctrl.md
Name: f1_reaction_ctrl

Overview:
Game controller that sequences the F1 lights-out datapath and measures driver reaction time. On a start request it pulses the lights block's trigger input and watches its 8-bit light pattern. It times the interval from lights-out (pattern 8'hFF -> 8'h00) to the react button in milliseconds. It flags jump starts and timeouts, and tracks the best time since reset for the display logic.

Parameters:
LIGHTS_WIDTH, 8, width of the light pattern from the lights block
CLKS_PER_MS, 50000, clock cycles per millisecond tick (prescaler terminal count + 1); must be >= 2
TIME_WIDTH, 16, width of reaction-time and best-time counters
TIMEOUT_MS, 2000, react window in ms before abort with timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
start_btn  in  1  start request, already synchronised; rising edge is used
react_btn  in  1  driver button, already synchronised; rising edge is used
lights  in  LIGHTS_WIDTH  light pattern from lights block data_out
trigger  out  1  one-cycle pulse to lights block trigger
busy  out  1  high in every state except IDLE and the result states
react_time  out  TIME_WIDTH  last measured reaction time in ms
result_valid  out  1  one-cycle pulse when react_time is updated
jump_start  out  1  sticky; set on a react edge before lights-out
timeout  out  1  sticky; set when TIMEOUT_MS elapses without a react edge
best_time  out  TIME_WIDTH  minimum valid react_time since reset; all-ones = none yet

Behaviour:
- Reset (rst==0 at posedge): state IDLE; trigger=0, result_valid=0, jump_start=0, timeout=0, react_time=0, best_time=all-ones. Prescaler and ms counter are cleared. Edge-detect registers load the current button levels, so a button held through reset produces no edge.
- Edges: start_rise and react_rise are registered-level versus current-level comparisons, each valid for one cycle.
- IDLE: on start_rise -> ARM. jump_start and timeout are cleared on this transition.
- ARM: trigger=1 for exactly this one cycle -> SEQ.
- SEQ (lights building): react_rise -> JUMP. lights==all-ones -> FULL.
- FULL (all lit, random hold): react_rise -> JUMP. lights==0 -> TIMING, with prescaler=0 and ms counter=0 on entry. react_rise takes priority over lights==0 in the same cycle.
- TIMING:
  - Prescaler counts 0..CLKS_PER_MS-1; at terminal count the ms counter increments.
  - react_rise -> DONE. react_time<=ms counter, result_valid=1 for one cycle. If ms counter < best_time, best_time<=ms counter.
  - A react_rise in the same cycle as a ms increment captures the pre-increment value.
  - ms counter reaching TIMEOUT_MS -> TOUT (timeout=1, react_time unchanged), unless react_rise occurs that cycle.
  - The ms counter saturates and never wraps.
- JUMP: jump_start=1, react_time unchanged, best_time unchanged -> IDLE next cycle.
- TOUT: -> IDLE next cycle.
- DONE: -> IDLE next cycle.
- busy=1 in ARM, SEQ, FULL, TIMING.
- start_rise while busy is ignored; no re-trigger.
- A reaction of 0 ms is valid (react within the first ms).
- Mid-operation reset returns to IDLE within one cycle. The lights block is reset separately by the top level.
- Latency: start_rise to trigger is 1 cycle. react_rise to result_valid is 1 cycle (registered).

Decomposition:
- Package f1_game_pkg holds:
  - state enum typedef state_t {IDLE, ARM, SEQ, FULL, TIMING, DONE, JUMP, TOUT}
  - LIGHTS_ALL_ON constant
  - default CLKS_PER_MS and TIMEOUT_MS constants
- One sub-module, ms_timer: prescaler plus saturating ms counter, with clear, enable, ms_count and limit_hit outputs.

Test Plan (CLKS_PER_MS=4, TIMEOUT_MS=20):
- Normal run: start_btn edge -> trigger high exactly 1 cycle after. Drive lights 01,03..FF then 00. React 4*7+1 cycles after lights==00 -> result_valid pulse, react_time=7, best_time=7, busy=0.
- Second run with react after 3 ms -> react_time=3, best_time=3. Third run with 9 ms -> react_time=9, best_time stays 3.
- Jump start: react edge while lights=0F (SEQ) -> jump_start=1, no result_valid, react_time and best_time unchanged, IDLE. Repeat with react during FULL -> same response.
- Simultaneous: react_rise in the same cycle lights goes FF->00 -> jump_start=1.
- Timeout: no react after lights-out -> timeout=1 after 20 ms (80 cycles), IDLE. A later react edge has no effect. A new start clears timeout.
- Reset mid-TIMING (rst=0 one cycle) -> IDLE, outputs at reset values, best_time=FFFF. start_btn held high through reset produces no trigger.
